// File: rtl/backward_maccum_pkg.sv
// backward_maccum_pkg: shared widths, FSM encoding and fixed-point product scaling.
package backward_maccum_pkg;
  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
  function automatic int acc_width(input int nc, input int wf);
    return $clog2(nc) + wf;
  endfunction
  // Shared with the forward path so both directions round identically (floor).
  function automatic logic signed [63:0] prod(input logic signed [31:0] a, input logic signed [31:0] b, input int fr);
    return (64'(a) * 64'(b)) >>> fr;
  endfunction
endpackage

// File: rtl/backward_maccum_lane.sv
// backward_maccum_lane: one producer-neuron multiply-accumulate lane.
module backward_maccum_lane import backward_maccum_pkg::*; #(
  parameter int WF = 5,
  parameter int FR = 3,
  parameter int WA = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [WF-1:0] w,
  input  logic signed [WF-1:0] d,
  input  logic                 first,
  input  logic                 en,
  output logic signed [WA-1:0] sum
);
  logic signed [WA-1:0] acc;
  assign sum = (first ? '0 : acc) + WA'(prod(32'(w), 32'(d), FR));
  always_ff @(posedge clk) acc <= rst ? '0 : en ? sum : acc;
endmodule

// File: rtl/backward_maccum.sv
// backward_maccum: time-multiplexed delta back-propagation, NP lanes over NC consumer steps.
module backward_maccum import backward_maccum_pkg::*; #(
  parameter int    NP    = 7,
  parameter int    NC    = 11,
  parameter int    WF    = 5,
  parameter int    FR    = 3,
  parameter string BURST = "yes",
  localparam int   WA    = acc_width(NC, WF)
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iValid_AM_Weight,
  output logic                oReady_AM_Weight,
  input  logic [NC*NP*WF-1:0] iData_AM_Weight,
  input  logic                iValid_AM_Delta,
  output logic                oReady_AM_Delta,
  input  logic [NC*WF-1:0]    iData_AM_Delta,
  output logic                oValid_BM_Prop,
  input  logic                iReady_BM_Prop,
  output logic [NP*WA-1:0]    oData_BM_Prop
);
  localparam int CW = $clog2(NC);
  state_t state, nxt;
  logic have_w, have_d, accept, hs_w, hs_d, hs_out, last;
  logic [NC*NP*WF-1:0] w_reg;
  logic [NC*WF-1:0] d_reg;
  logic [CW-1:0] c;
  logic [NP*WA-1:0] sums;
  assign accept = state == IDLE || (BURST == "yes" && state == OUT);
  assign oReady_AM_Weight = !iRST && !have_w && accept;
  assign oReady_AM_Delta = !iRST && !have_d && accept;
  assign hs_w = iValid_AM_Weight && oReady_AM_Weight;
  assign hs_d = iValid_AM_Delta && oReady_AM_Delta;
  assign oValid_BM_Prop = state == OUT;
  assign hs_out = oValid_BM_Prop && iReady_BM_Prop;
  assign last = state == RUN && c == CW'(NC - 1);
  // IDLE counts an arrival in the current cycle so RUN starts right after the later handshake.
  always_comb
    nxt = state == IDLE ? ((have_w || hs_w) && (have_d || hs_d) ? RUN : IDLE)
        : state == RUN ? (last ? OUT : RUN)
        : hs_out ? (have_w && have_d ? RUN : IDLE) : OUT;
  always_ff @(posedge iCLK)
    if (iRST) begin
      state <= IDLE;
      have_w <= 1'b0;
      have_d <= 1'b0;
      c <= '0;
      oData_BM_Prop <= '0;
    end else begin
      state <= nxt;
      c <= last ? '0 : state == RUN ? c + CW'(1) : c;
      have_w <= hs_w || (have_w && !last);
      have_d <= hs_d || (have_d && !last);
      if (last) oData_BM_Prop <= sums;
    end
  always_ff @(posedge iCLK) begin
    if (hs_w) w_reg <= iData_AM_Weight;
    if (hs_d) d_reg <= iData_AM_Delta;
  end
  for (genvar p = 0; p < NP; p++) begin : g_lane
    backward_maccum_lane #(.WF(WF), .FR(FR), .WA(WA)) u_lane (
      .clk(iCLK),
      .rst(iRST),
      .w(w_reg[(int'(c) * NP + p) * WF +: WF]),
      .d(d_reg[int'(c) * WF +: WF]),
      .first(c == '0),
      .en(state == RUN),
      .sum(sums[p*WA +: WA])
    );
  end
endmodule
